ps2_tx_interface: RTL and testbench

Host-to-device PS/2 transmitter. It is the send side of the keyboard port, complementing the existing receive-only `ps2_interface`. The processor writes a command byte, for example `0xED` (set LEDs) or `0xFF` (reset). The block runs the PS/2 request-to-send sequence, clocks the byte out under device-generated clocks with odd parity, and checks the device's acknowledge bit. It sits on the CPU IO bus in the `0x0f` class alongside the other IO registers, and shares the `ps2a_clock`/`ps2a_data` open-drain pins with the receiver.

---
 rtl/ps2_tx_interface.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ps2_tx_interface.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx_interface.sv
// ps2_tx_interface
//
// Host-to-device PS/2 transmitter for the keyboard port. The CPU writes a
// command byte into the data register; the block inhibits the bus, issues
// request-to-send, shifts the byte out LSB first with odd parity under the
// device-generated clock, and checks the device's acknowledge bit.
//
// Bus map (IO class 0x0f):
//   data_cs   : command register, write only, byte taken from data_in[7:0]
//   status_cs : status register, read only,
//               data_out = {29'b0, timeout, ack_error, busy}
//
// The ps2_clock / ps2_data pins are open drain and shared with the receive
// side. They are only ever driven 0 or released (z).
//
// Optional feature, selected at build time:
//   PS2_TX_TIMEOUT_EN - watchdog that abandons a transfer when the device
//                       stops clocking for TIMEOUT_CYCLES and sets 'timeout'.
//                       When undefined no counter exists and 'timeout' is 0.

`timescale 1ns/1ps

module ps2_tx_interface #(
  parameter int unsigned INHIBIT_CYCLES = 1250,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        data_cs,
  input  logic        status_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  inout  wire         ps2_clock,
  inout  wire         ps2_data
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Registers and internal signals
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [7:0]       tx_byte;
  logic             tx_parity;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inhibit_cnt;
  logic             clk_drive_low;
  logic             data_drive_low;
  logic             ack_error;
  logic             timeout;

  logic             clk_meta;
  logic             clk_sync;
  logic             clk_prev;
  logic             data_meta;
  logic             data_sync;

  logic             dev_fall;
  logic             busy;
  logic             cmd_write;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0]  wd_cnt;
  logic             timeout_flag;
  logic             unused_ok;

  assign timeout   = timeout_flag;
  assign unused_ok = ^data_in[31:8];
`else
  logic             unused_ok;

  // Without the watchdog there is nothing that can time out.
  assign timeout   = 1'b0;
  assign unused_ok = ^{data_in[31:8], (TIMEOUT_CYCLES == 0)};
`endif

  // ---------------------------------------------------------------------------
  // Open-drain pin drivers: only ever pull low or release.
  // ---------------------------------------------------------------------------
  assign ps2_clock = clk_drive_low  ? 1'b0 : 1'bz;
  assign ps2_data  = data_drive_low ? 1'b0 : 1'bz;

  assign busy      = (state != S_IDLE);
  assign cmd_write = write && data_cs;
  assign dev_fall  = clk_prev && !clk_sync;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for both pins plus the previous clock sample used
  // for falling-edge detection. The idle bus is high, so reset to 1 to avoid
  // a phantom edge when reset is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments give each flop the value its
      // predecessor held before the edge; blocking ones would collapse the
      // synchroniser chain into a single stage.
      clk_meta  <= ps2_clock;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit state machine with registered pin drives and status bits.
  // Pin drives are reset asynchronously so the bus is released the moment
  // reset is asserted, even mid-transfer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      tx_byte        <= 8'h00;
      tx_parity      <= 1'b0;
      bit_cnt        <= 4'd0;
      inhibit_cnt    <= '0;
      clk_drive_low  <= 1'b0;
      data_drive_low <= 1'b0;
      ack_error      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt         <= '0;
      timeout_flag   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          clk_drive_low  <= 1'b0;
          data_drive_low <= 1'b0;
          if (cmd_write) begin
            tx_byte       <= data_in[7:0];
            tx_parity     <= ~^data_in[7:0];
            ack_error     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            timeout_flag  <= 1'b0;
`endif
            bit_cnt       <= 4'd0;
            inhibit_cnt   <= '0;
            clk_drive_low <= 1'b1;
            state         <= S_INHIBIT;
          end
        end

        // Hold the clock low long enough that the device aborts anything it
        // was sending, then present the start bit and hand the clock over.
        S_INHIBIT: begin
          if (inhibit_cnt == INH_LAST) begin
            clk_drive_low  <= 1'b0;
            data_drive_low <= 1'b1;
            state          <= S_RTS;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
          end else begin
            inhibit_cnt <= inhibit_cnt + 1'b1;
          end
        end

        // First device clock: put bit 0 on the line.
        S_RTS: begin
          if (dev_fall) begin
            data_drive_low <= ~tx_byte[0];
            bit_cnt        <= 4'd1;
            state          <= S_DATA;
          end
        end

        // Bits 1..7 on successive falling edges, then parity once bit 7 is out.
        S_DATA: begin
          if (dev_fall) begin
            if (bit_cnt == 4'd8) begin
              data_drive_low <= ~tx_parity;
              state          <= S_PARITY;
            end else begin
              data_drive_low <= ~tx_byte[bit_cnt[2:0]];
              bit_cnt        <= bit_cnt + 4'd1;
            end
          end
        end

        // Release data: the stop bit is a released (high) line.
        S_PARITY: begin
          if (dev_fall) begin
            data_drive_low <= 1'b0;
            state          <= S_STOP;
          end
        end

        // Eleventh falling edge: the device should be holding data low.
        S_STOP: begin
          if (dev_fall) begin
            ack_error <= data_sync;
            state     <= S_WAIT_IDLE;
          end
        end

        // Do not report idle until the device has let go of both lines.
        S_WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            state <= S_IDLE;
          end
        end

        default: begin
          clk_drive_low  <= 1'b0;
          data_drive_low <= 1'b0;
          state          <= S_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog: restarts on every device clock, abandons the transfer if
      // the device goes quiet. A falling edge in the same cycle wins.
      if (state inside {S_RTS, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE}) begin
        if (dev_fall) begin
          wd_cnt <= '0;
        end else if (wd_cnt == WD_LAST) begin
          clk_drive_low  <= 1'b0;
          data_drive_low <= 1'b0;
          timeout_flag   <= 1'b1;
          wd_cnt         <= '0;
          state          <= S_IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Status read port: combinational from the strobe and registered state, so
  // a read in the same cycle as a command write returns the pre-write status.
  // ---------------------------------------------------------------------------
  assign data_out_valid = read && status_cs;

  // Status word mux, zero when the register is not being read.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives data_out,
    // so no latch is inferred when the read is not selected.
    data_out = 32'h0;
    if (data_out_valid) begin
      data_out = {29'b0, timeout, ack_error, busy};
    end
  end

endmodule

// File: tb/tb_ps2_tx_interface.sv
// tb_ps2_tx_interface
//
// Directed bench for ps2_tx_interface. A behavioural PS/2 device generates
// the device clock, samples the host's bits on its rising edges and
// optionally acknowledges. Expected frames and status words are queued when
// stimulus is issued; independent monitors pop and compare whenever the DUT
// presents a status read or the device finishes receiving a frame.

`timescale 1ns/1ps

module tb_ps2_tx_interface;

  localparam int HALF        = 20;     // device clock half period in system clocks
  localparam int INHIBIT     = 1250;
  localparam int TIMEOUT     = 2000;
  localparam int WAIT_BOUND  = 5000;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic        data_cs;
  logic        status_cs;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_valid;

  logic        dev_clk_low;
  logic        dev_data_low;
  wire         ps2_clk_net;
  wire         ps2_data_net;

  assign ps2_clk_net  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data_net = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2_clk_net);
  pullup (ps2_data_net);

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_status_q[$];
  logic [10:0] exp_frame_q[$];
  logic [10:0] act_frame_q[$];

  ps2_tx_interface #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .write          (write),
    .data_cs        (data_cs),
    .status_cs      (status_cs),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .ps2_clock      (ps2_clk_net),
    .ps2_data       (ps2_data_net)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: wait bound of %0d cycles expired", name, WAIT_BOUND);
  endtask

  // Status monitor: every presented read is matched against the queue.
  always @(negedge clock) begin
    if (data_out_valid) begin
      if (exp_status_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL status_unexpected: got 0x%0h with no read expected", data_out);
      end else begin
        check("status", data_out, exp_status_q.pop_front());
      end
    end
  end

  // Frame monitor: every frame the device model received is matched.
  always @(negedge clock) begin
    if (act_frame_q.size() > 0) begin
      logic [10:0] act;
      act = act_frame_q.pop_front();
      if (exp_frame_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL frame_unexpected: got 0x%0h with no frame expected", act);
      end else begin
        check("frame", {21'b0, act}, {21'b0, exp_frame_q.pop_front()});
      end
    end
  end

  task automatic bus_write(input logic [7:0] b, input bit with_read, input logic [31:0] exp_rd);
    @(posedge clock); #1;
    write   = 1'b1;
    data_cs = 1'b1;
    data_in = {24'hA5A5A5, b};
    if (with_read) begin
      read      = 1'b1;
      status_cs = 1'b1;
      exp_status_q.push_back(exp_rd);
    end
    @(posedge clock); #1;
    write     = 1'b0;
    data_cs   = 1'b0;
    read      = 1'b0;
    status_cs = 1'b0;
    data_in   = 32'h0;
  endtask

  task automatic status_read(input logic [31:0] exp_rd);
    @(posedge clock); #1;
    read      = 1'b1;
    status_cs = 1'b1;
    exp_status_q.push_back(exp_rd);
    @(posedge clock); #1;
    read      = 1'b0;
    status_cs = 1'b0;
  endtask

  // Behavioural device: waits for inhibit, measures it, samples start bit,
  // then generates n_clk clocks, sampling data before each rising edge.
  task automatic device_xfer(input int n_clk, input bit do_ack, input bit chk_inhibit);
    int          wait_cnt;
    int          low_cnt;
    logic [10:0] fr;
    fr       = '1;
    wait_cnt = 0;
    do begin
      @(negedge clock);
      wait_cnt++;
    end while (ps2_clk_net !== 1'b0 && wait_cnt < WAIT_BOUND);
    if (ps2_clk_net !== 1'b0) begin
      bound_fail("inhibit_start");
      return;
    end
    low_cnt = 0;
    while (ps2_clk_net === 1'b0 && low_cnt < WAIT_BOUND) begin
      low_cnt++;
      @(negedge clock);
    end
    if (low_cnt >= WAIT_BOUND) begin
      bound_fail("inhibit_end");
      return;
    end
    if (chk_inhibit) check("inhibit_len", low_cnt, INHIBIT);
    repeat (2) @(negedge clock);
    fr[0] = ps2_data_net;
    for (int i = 1; i <= n_clk; i++) begin
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      if (i <= 10) fr[i] = ps2_data_net;
      dev_clk_low = 1'b0;
      if (i == 10) dev_data_low = do_ack;
      if (i == 11) dev_data_low = 1'b0;
    end
    if (n_clk == 11) act_frame_q.push_back(fr);
  endtask

  // Absolute safety net so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    reset        = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    data_cs      = 1'b0;
    status_cs    = 1'b0;
    data_in      = 32'h0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ps2_clock", {31'b0, ps2_clk_net}, 32'h1);
    check("rst_ps2_data", {31'b0, ps2_data_net}, 32'h1);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", {31'b0, data_out_valid}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // 0xED with ack; write and status read in the same cycle see pre-write status
    bus_write(8'hED, 1'b1, 32'h0);
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    device_xfer(11, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    status_read(32'h0);

    // 0x01: parity 0
    bus_write(8'h01, 1'b0, 32'h0);
    exp_frame_q.push_back({1'b1, 1'b0, 8'h01, 1'b0});
    device_xfer(11, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    status_read(32'h0);

    // 0xFF with no ack -> ack_error
    bus_write(8'hFF, 1'b0, 32'h0);
    exp_frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
    device_xfer(11, 1'b0, 1'b1);
    repeat (10) @(posedge clock);
    status_read(32'h2);

    // 0x00 clears the error bit as soon as it is accepted
    bus_write(8'h00, 1'b0, 32'h0);
    exp_frame_q.push_back({1'b1, 1'b1, 8'h00, 1'b0});
    status_read(32'h1);
    device_xfer(11, 1'b1, 1'b0);
    repeat (10) @(posedge clock);
    status_read(32'h0);

    // 0x55 written while busy with 0xED is ignored
    bus_write(8'hED, 1'b0, 32'h0);
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    repeat (5) @(posedge clock);
    status_read(32'h1);
    @(posedge clock); #1;
    read      = 1'b1;
    status_cs = 1'b0;
    @(negedge clock);
    check("unselected_valid", {31'b0, data_out_valid}, 32'h0);
    check("unselected_data", data_out, 32'h0);
    @(posedge clock); #1;
    read = 1'b0;
    bus_write(8'h55, 1'b1, 32'h1);
    device_xfer(11, 1'b1, 1'b0);
    repeat (10) @(posedge clock);
    status_read(32'h0);

    // Reset after the 4th device clock releases both lines immediately
    bus_write(8'hF0, 1'b0, 32'h0);
    device_xfer(4, 1'b1, 1'b1);
    #1;
    check("pre_reset_data_low", {31'b0, ps2_data_net}, 32'h0);
    reset = 1'b0;
    #1;
    check("reset_ps2_clock", {31'b0, ps2_clk_net}, 32'h1);
    check("reset_ps2_data", {31'b0, ps2_data_net}, 32'h1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    status_read(32'h0);

    // No device clocks after request-to-send
    bus_write(8'h3C, 1'b0, 32'h0);
`ifdef PS2_TX_TIMEOUT_EN
    repeat (INHIBIT + TIMEOUT + 20) @(negedge clock);
    status_read(32'h4);
    @(negedge clock);
    check("timeout_ps2_clock", {31'b0, ps2_clk_net}, 32'h1);
    check("timeout_ps2_data", {31'b0, ps2_data_net}, 32'h1);
`else
    repeat (INHIBIT + 3000) @(negedge clock);
    status_read(32'h1);
    @(negedge clock);
    check("hang_ps2_data_low", {31'b0, ps2_data_net}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    status_read(32'h0);
`endif

    repeat (5) @(negedge clock);
    check("frames_outstanding", exp_frame_q.size(), 32'h0);
    check("status_outstanding", exp_status_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
